// File: rtl/ar_frame_pkg.sv
// Shared types and default constants for the AR9331 frame transmitter.
package ar_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_FETCH    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_GAP      = 3'd4,
    ST_CSUM     = 3'd5
  } state_e;

  localparam logic [7:0]  AR_HDR_WORD    = 8'h36;
  localparam int unsigned AR_GAP_CYC     = 1024;
  localparam int unsigned AR_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/ar_frame_tx_if.sv
// Upstream valid/ready source plus host toggle-strobe bus of ar_frame_tx.
interface ar_frame_tx_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic          ack;
  logic          clk_out;
  logic [DW-1:0] data_out;
  logic          data_oe;

  modport master (
    input  src_data, src_valid, ack,
    output src_ready, clk_out, data_out, data_oe
  );

  modport slave (
    output src_data, src_valid, ack,
    input  src_ready, clk_out, data_out, data_oe
  );
endinterface

// File: rtl/ar_toggle_sync.sv
// 2-FF synchroniser for an asynchronous toggle line plus last-seen level compare.
module ar_toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tog_in,
  input  logic track,
  input  logic consume,
  output logic evt
);
  logic [1:0] sync;
  logic       seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      seen <= 1'b0;
    end else begin
      sync <= {sync[0], tog_in};
      // Pending toggles are a level difference, not a count.
      if (track || consume) seen <= sync[1];
    end
  end

  assign evt = sync[1] ^ seen;
endmodule

// File: rtl/ar_frame_tx.sv
// Frame transmitter to the AR9331 host: header, len_in payload words, gap.
// Define AR_FRAME_CSUM_EN to append an inverted mod-2^DW checksum word.
module ar_frame_tx
  import ar_frame_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned LEN_W       = 16,
  parameter logic [7:0]  HDR_WORD    = AR_HDR_WORD,
  parameter int unsigned GAP_CYC     = AR_GAP_CYC,
  parameter int unsigned TIMEOUT_CYC = AR_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len_in,
  ar_frame_tx_if.master    bus,
  output logic             busy,
  output logic             timeout_err,
  output logic [2:0]       state_o
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  state_e           state, state_d;
  logic [LEN_W-1:0] rem;
  logic [TW-1:0]    tcnt;
  logic [GW-1:0]    gcnt;
  logic             ack_evt, in_idle;
  logic             load, send_hdr, pop, consume, abort;
`ifdef AR_FRAME_CSUM_EN
  logic [DW-1:0]    sum;
  logic             csum_sent, send_csum;
`endif

  assign in_idle = (state == ST_IDLE);

  ar_toggle_sync u_ack_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .tog_in  (bus.ack),
    .track   (in_idle),
    .consume (consume),
    .evt     (ack_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    send_hdr = 1'b0;
    pop      = 1'b0;
    consume  = 1'b0;
    abort    = 1'b0;
`ifdef AR_FRAME_CSUM_EN
    send_csum = 1'b0;
`endif
    unique case (state)
      ST_IDLE: if (start) begin
        load    = 1'b1;
        state_d = ST_HDR;
      end
      ST_HDR: begin
        send_hdr = 1'b1;
        state_d  = ST_WAIT_ACK;
      end
      ST_FETCH: if (bus.src_valid) begin
        pop     = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_evt) begin
          consume = 1'b1;
          if (rem != '0) state_d = ST_FETCH;
`ifdef AR_FRAME_CSUM_EN
          else if (!csum_sent) state_d = ST_CSUM;
`endif
          else state_d = ST_GAP;
        end else if (tcnt == TW'(TIMEOUT_CYC)) begin
          abort   = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: if (gcnt == GW'(GAP_CYC - 1)) state_d = ST_IDLE;
`ifdef AR_FRAME_CSUM_EN
      ST_CSUM: begin
        send_csum = 1'b1;
        state_d   = ST_WAIT_ACK;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem          <= '0;
      tcnt         <= '0;
      gcnt         <= '0;
      bus.clk_out  <= 1'b0;
      bus.data_out <= '0;
      bus.data_oe  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (load) begin
        rem         <= len_in;
        timeout_err <= 1'b0;
      end
      if (send_hdr) begin
        bus.data_out <= DW'(HDR_WORD);
        bus.data_oe  <= 1'b1;
        bus.clk_out  <= ~bus.clk_out;
      end
      if (pop) begin
        bus.data_out <= bus.src_data;
        bus.clk_out  <= ~bus.clk_out;
        rem          <= rem - LEN_W'(1);
      end
`ifdef AR_FRAME_CSUM_EN
      if (send_csum) begin
        bus.data_out <= ~sum;
        bus.clk_out  <= ~bus.clk_out;
      end
`endif
      if (abort) timeout_err <= 1'b1;
      // Bus released on entry to GAP, whether by completion or abort.
      if (state_d == ST_GAP) bus.data_oe <= 1'b0;
      tcnt <= (state == ST_WAIT_ACK && !ack_evt) ? tcnt + TW'(1) : '0;
      gcnt <= (state == ST_GAP) ? gcnt + GW'(1) : '0;
    end
  end

`ifdef AR_FRAME_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      csum_sent <= 1'b0;
    end else begin
      if (load) begin
        sum       <= '0;
        csum_sent <= 1'b0;
      end
      if (send_hdr)  sum       <= sum + DW'(HDR_WORD);
      if (pop)       sum       <= sum + bus.src_data;
      if (send_csum) csum_sent <= 1'b1;
    end
  end
`endif

  assign bus.src_ready = pop;
  assign busy          = !in_idle;
  assign state_o       = state;
endmodule

// File: tb/tb_ar_frame_tx.sv
// Directed scoreboard bench for ar_frame_tx; host ack model answers each strobe.
`define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_ar_frame_tx;
  import ar_frame_pkg::*;

  localparam int unsigned DW = 8, LEN_W = 16, GAP = 20, TMO = 100;
  localparam int ACK_DLY  = 5;
  localparam int SYNC_LAT = 3;
`ifdef AR_FRAME_CSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [LEN_W-1:0] len_in = '0;
  logic busy, timeout_err;
  logic [2:0] state_o;

  ar_frame_tx_if #(.DW(DW)) bus ();

  ar_frame_tx #(
    .DW(DW), .LEN_W(LEN_W), .HDR_WORD(8'h36), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_in(len_in), .bus(bus),
    .busy(busy), .timeout_err(timeout_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [DW-1:0] pay_q[$], exp_q[$], src_q[$];
  int n_tog, n_rdy, n_gap, ack_to_idle, to_age, proto_err, tog_total;
  logic oe_at_to, busy_first, err_first, done;
  logic [DW-1:0] last_word;

  task automatic chk_reset_vals();
    `CHK("rst_clk_out", bus.clk_out, 1'b0)
    `CHK("rst_data_out", bus.data_out, 8'h00)
    `CHK("rst_data_oe", bus.data_oe, 1'b0)
    `CHK("rst_src_ready", bus.src_ready, 1'b0)
    `CHK("rst_timeout_err", timeout_err, 1'b0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_state", state_o, 3'd0)
  endtask

  // Runs one frame from pay_q; entered and left just after a falling edge.
  task automatic run_frame(input bit ack_en, input bit hold, input int stall_word,
                           input int stall_cyc, input int abort_tog, input int max_cyc);
    logic last_clk, awaiting, pop_pending, seen_busy;
    int ack_timer, ack_age, tog_age, stall_left, popped;
    logic [DW-1:0] presented, e;
`ifdef AR_FRAME_CSUM_EN
    logic [DW-1:0] sum;
    sum = 8'h36;
`endif
    exp_q.delete();
    src_q.delete();
    exp_q.push_back(8'h36);
    foreach (pay_q[i]) begin
      exp_q.push_back(pay_q[i]);
      src_q.push_back(pay_q[i]);
`ifdef AR_FRAME_CSUM_EN
      sum = sum + pay_q[i];
`endif
    end
`ifdef AR_FRAME_CSUM_EN
    exp_q.push_back(~sum);
`endif
    len_in = LEN_W'(pay_q.size());
    `CHK("clk_out_parity", bus.clk_out, tog_total[0])
    last_clk = bus.clk_out; awaiting = 0; pop_pending = 0; seen_busy = 0;
    ack_timer = 0; ack_age = 0; tog_age = 0; stall_left = stall_cyc; popped = 0;
    presented = '0;
    n_tog = 0; n_rdy = 0; n_gap = 0; ack_to_idle = -1; to_age = -1; proto_err = 0;
    oe_at_to = 1'bx; done = 0;
    start = 1'b1;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      ack_age++;
      tog_age++;
      if (cyc == 0) begin
        busy_first = busy;
        err_first  = timeout_err;
      end
      if (awaiting && ack_en) begin
        if (ack_timer == 0) begin
          bus.ack = ~bus.ack;
          awaiting = 0;
          ack_age = 0;
        end else ack_timer--;
      end
      if (bus.clk_out !== last_clk) begin
        last_clk = bus.clk_out;
        n_tog++;
        tog_total++;
        tog_age = 0;
        if (awaiting || exp_q.size() == 0) proto_err++;
        else begin
          e = exp_q.pop_front();
          `CHK("word", bus.data_out, e)
          `CHK("oe_on_toggle", bus.data_oe, 1'b1)
        end
        presented = bus.data_out;
        last_word = bus.data_out;
        awaiting = 1;
        ack_timer = ACK_DLY;
      end else if (awaiting && bus.data_out !== presented) proto_err++;
      if (state_o == ST_GAP) n_gap++;
      if (to_age < 0 && timeout_err === 1'b1) begin
        to_age = tog_age;
        oe_at_to = bus.data_oe;
      end
      if (pop_pending) begin
        void'(src_q.pop_front());
        popped++;
        pop_pending = 0;
      end
      if (busy) seen_busy = 1;
      else if (seen_busy) begin
        done = 1;
        ack_to_idle = ack_age;
      end
      if (abort_tog > 0 && n_tog == abort_tog) done = 1;
      if (popped == stall_word && stall_left > 0) begin
        stall_left--;
        bus.src_valid = 1'b0;
        if (stall_left == 0) begin
          `CHK("stall_in_fetch", state_o, 3'd2)
          `CHK("stall_no_timeout", timeout_err, 1'b0)
          `CHK("stall_no_toggle", n_tog, stall_word + 1)
        end
      end else if (src_q.size() > 0) begin
        bus.src_valid = 1'b1;
        bus.src_data  = src_q[0];
      end else bus.src_valid = 1'b0;
      #1;
      if (bus.src_ready === 1'b1) begin
        n_rdy++;
        pop_pending = 1;
      end
    end
    `CHK("frame_done", done, 1'b1)
    `CHK("protocol", proto_err, 0)
    if (ack_en && abort_tog == 0) `CHK("scoreboard_empty", exp_q.size(), 0)
  endtask

  initial begin
    bus.ack = 1'b0; bus.src_valid = 1'b0; bus.src_data = '0;
    tog_total = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal three-word frame
    pay_q = '{8'h11, 8'h22, 8'h33};
    run_frame(1, 0, -1, 0, 0, 2000);
    `CHK("a_toggles", n_tog, 4 + EXTRA)
    `CHK("a_ready_pulses", n_rdy, 3)
    `CHK("a_ack_to_idle", ack_to_idle, GAP + SYNC_LAT)
    `CHK("a_gap_cycles", n_gap, GAP)
    `CHK("a_no_timeout", timeout_err, 1'b0)

    // Header-only frame
    pay_q.delete();
    run_frame(1, 0, -1, 0, 0, 2000);
    `CHK("b_toggles", n_tog, 1 + EXTRA)
    `CHK("b_ready_pulses", n_rdy, 0)
    `CHK("b_ack_to_idle", ack_to_idle, GAP + SYNC_LAT)

    // Host never acks the header
    pay_q = '{8'h44, 8'h55};
    run_frame(0, 0, -1, 0, 0, 2000);
    `CHK("c_timeout_cycle", to_age, TMO + 1)
    `CHK("c_oe_at_timeout", oe_at_to, 1'b0)
    `CHK("c_toggles", n_tog, 1)
    `CHK("c_ready_pulses", n_rdy, 0)
    `CHK("c_err_sticky", timeout_err, 1'b1)
    `CHK("c_idle", state_o, 3'd0)

    // Next start clears the sticky flag
    pay_q = '{8'h66};
    run_frame(1, 0, -1, 0, 0, 2000);
    `CHK("d_err_cleared", err_first, 1'b0)
    `CHK("d_toggles", n_tog, 2 + EXTRA)

    // Upstream stalls well beyond the ack timeout while in FETCH
    pay_q = '{8'h71, 8'h72, 8'h73};
    run_frame(1, 0, 1, 200, 0, 3000);
    `CHK("e_toggles", n_tog, 4 + EXTRA)
    `CHK("e_ready_pulses", n_rdy, 3)
    `CHK("e_no_timeout", timeout_err, 1'b0)

    // Reset while waiting for the ack of payload word 2 of 5
    pay_q = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
    run_frame(1, 0, -1, 0, 3, 2000);
    `CHK("f_in_wait_ack", state_o, 3'd3)
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    tog_total = 0;
    @(negedge clk);
    bus.src_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    pay_q = '{8'h91};
    run_frame(1, 0, -1, 0, 0, 2000);
    `CHK("f_toggles_after_reset", n_tog, 2 + EXTRA)

    // start held high: back-to-back frames
    pay_q = '{8'hA1};
    run_frame(1, 1, -1, 0, 0, 2000);
    `CHK("g_gap_cycles", n_gap, GAP)
    pay_q = '{8'hA2};
    run_frame(1, 1, -1, 0, 0, 2000);
    start = 1'b0;
    `CHK("g_single_idle_cycle", busy_first, 1'b1)
    `CHK("g_toggles", n_tog, 2 + EXTRA)

`ifdef AR_FRAME_CSUM_EN
    pay_q = '{8'h01, 8'h02};
    run_frame(1, 0, -1, 0, 0, 2000);
    `CHK("h_toggles", n_tog, 4)
    `CHK("h_trailer", last_word, 8'hC6)
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
